// File: rtl/dsp_fix_pkg.sv
// Shared fixed-point helpers and sequencer state encoding for the IIR stages.
package dsp_fix_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        SCALE,
        HOLD
    } fix_state_e;

    localparam int unsigned SATW = 128;

    // Clamp a signed value to the n-bit two's complement range; caller narrows the result.
    function automatic logic signed [SATW-1:0] sat_w(input logic signed [SATW-1:0] v,
                                                     input int unsigned             n);
        logic signed [SATW-1:0] hi;
        logic signed [SATW-1:0] lo;
        hi = $signed((SATW'(1) << (n - 1)) - SATW'(1));
        lo = ~hi;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    function automatic longint to_fix(input real v, input int unsigned fsw);
        real    s;
        longint r;
        s = v * (2.0 ** fsw);
        r = longint'(s);
        // The cast rounds to nearest; pull back toward zero to truncate.
        if (s >= 0.0 && real'(r) > s) begin
            r = r - 1;
        end else if (s < 0.0 && real'(r) < s) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fix_mac_unit.sv
// Single signed multiplier with a wide add/subtract accumulator, shared by
// the tap accumulation and the final 1/B0 scaling.
module fix_mac_unit #(
    parameter int unsigned W  = 32,
    parameter int unsigned AW = 2 * W + 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  acc_load,
    input  logic signed [AW-1:0]  acc_load_val,
    input  logic                  acc_en,
    input  logic                  acc_sub,
    input  logic signed [W+1:0]   op_a,
    input  logic signed [W-1:0]   op_b,
    output logic signed [2*W+1:0] prod,
    output logic signed [AW-1:0]  acc
);

    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] acc_d;
    logic signed [AW-1:0] prod_ext;

    assign prod     = op_a * op_b;
    assign prod_ext = {{(AW - 2 * W - 2){prod[2*W+1]}}, prod};
    assign acc      = acc_q;

    always_comb begin
        acc_d = acc_q;
        if (acc_load) begin
            acc_d = acc_load_val;
        end else if (acc_en) begin
            acc_d = acc_sub ? (acc_q - prod_ext) : (acc_q + prod_ext);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/biquad_inverse_seq.sv
// Inverse biquad (equaliser): recovers u from a biquad-filtered stream x using
// one time-shared multiplier, 7 cycles per sample, valid/ready on both sides.
module biquad_inverse_seq
    import dsp_fix_pkg::*;
#(
    parameter int unsigned W      = 32,
    parameter int unsigned FSW    = 16,
    parameter real         B1     = 0.0,
    parameter real         B2     = 0.0,
    parameter real         A1     = 0.0,
    parameter real         A2     = 0.0,
    parameter real         INV_B0 = 1.0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_data
);

    localparam int unsigned AW = 2 * W + 4;
    localparam int unsigned PW = 2 * W + 2;

    localparam logic signed [W-1:0] A1_C  = W'(to_fix(A1, FSW));
    localparam logic signed [W-1:0] A2_C  = W'(to_fix(A2, FSW));
    localparam logic signed [W-1:0] B1_C  = W'(to_fix(B1, FSW));
    localparam logic signed [W-1:0] B2_C  = W'(to_fix(B2, FSW));
    localparam logic signed [W-1:0] INV_C = W'(to_fix(INV_B0, FSW));

    fix_state_e          state_q, state_d;
    logic [1:0]          step_q, step_d;
    logic signed [W-1:0] xs_q, xs_d;
    logic signed [W-1:0] x1_q, x1_d;
    logic signed [W-1:0] x2_q, x2_d;
    logic signed [W-1:0] u1_q, u1_d;
    logic signed [W-1:0] u2_q, u2_d;
    logic signed [W-1:0] out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;

    logic                acc_load;
    logic                acc_en;
    logic                acc_sub;
    logic signed [W+1:0] op_a;
    logic signed [W-1:0] op_b;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_load_val;
    logic signed [AW-1:0] acc_sh;
    logic signed [PW-1:0] prod_sh;
    logic signed [W+1:0]  r_sat;
    logic signed [W-1:0]  p_sat;

    fix_mac_unit #(
        .W  (W),
        .AW (AW)
    ) u_mac (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .acc_load     (acc_load),
        .acc_load_val (acc_load_val),
        .acc_en       (acc_en),
        .acc_sub      (acc_sub),
        .op_a         (op_a),
        .op_b         (op_b),
        .prod         (prod),
        .acc          (acc)
    );

    assign acc_load_val = $signed({{(AW - W){in_data[W-1]}}, in_data}) <<< FSW;
    // r feeds the multiplier in SCALE; the product is then rescaled and clamped.
    assign acc_sh  = acc >>> FSW;
    assign r_sat   = (W + 2)'(sat_w(SATW'(acc_sh), W + 2));
    assign prod_sh = prod >>> FSW;
    assign p_sat   = W'(sat_w(SATW'(prod_sh), W));

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        xs_d        = xs_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        u1_d        = u1_q;
        u2_d        = u2_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        acc_load    = 1'b0;
        acc_en      = 1'b0;
        acc_sub     = 1'b0;
        op_a        = '0;
        op_b        = '0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    xs_d     = in_data;
                    acc_load = 1'b1;
                    step_d   = '0;
                    state_d  = MAC;
                end
            end
            MAC: begin
                acc_en = 1'b1;
                case (step_q)
                    2'd0: begin
                        op_a = {{2{x1_q[W-1]}}, x1_q};
                        op_b = A1_C;
                    end
                    2'd1: begin
                        op_a = {{2{x2_q[W-1]}}, x2_q};
                        op_b = A2_C;
                    end
                    2'd2: begin
                        op_a    = {{2{u1_q[W-1]}}, u1_q};
                        op_b    = B1_C;
                        acc_sub = 1'b1;
                    end
                    default: begin
                        op_a    = {{2{u2_q[W-1]}}, u2_q};
                        op_b    = B2_C;
                        acc_sub = 1'b1;
                    end
                endcase
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    state_d = SCALE;
                end
            end
            SCALE: begin
                op_a        = r_sat;
                op_b        = INV_C;
                out_data_d  = p_sat;
                x2_d        = x1_q;
                x1_d        = xs_q;
                u2_d        = u1_q;
                u1_d        = p_sat;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            step_q      <= '0;
            xs_q        <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            u1_q        <= '0;
            u2_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (clr) begin
            state_q     <= IDLE;
            step_q      <= '0;
            xs_q        <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            u1_q        <= '0;
            u2_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            xs_q        <= xs_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            u1_q        <= u1_d;
            u2_q        <= u2_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_biquad_inverse_seq.sv
// Directed bench: an identity instance and an inverse-of-biquad instance share
// stimulus; sel chooses which one is driven and observed.
module tb_biquad_inverse_seq;

    localparam int W = 32;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic clr       = 1'b0;
    logic sel       = 1'b0;
    logic in_valid  = 1'b0;
    logic out_ready = 1'b0;
    logic [W-1:0] in_data = '0;

    logic iv_id, iv_rt, or_id, or_rt;
    logic ir_id, ir_rt, ov_id, ov_rt;
    logic signed [W-1:0] od_id, od_rt;
    logic in_ready, out_valid;
    logic signed [W-1:0] out_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign iv_id     = in_valid & ~sel;
    assign iv_rt     = in_valid & sel;
    assign or_id     = out_ready & ~sel;
    assign or_rt     = out_ready & sel;
    assign in_ready  = sel ? ir_rt : ir_id;
    assign out_valid = sel ? ov_rt : ov_id;
    assign out_data  = sel ? od_rt : od_id;

    biquad_inverse_seq #(
        .W   (32),
        .FSW (16)
    ) u_id (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (iv_id),
        .in_ready  (ir_id),
        .in_data   (in_data),
        .out_valid (ov_id),
        .out_ready (or_id),
        .out_data  (od_id)
    );

    biquad_inverse_seq #(
        .W      (32),
        .FSW    (16),
        .B1     (0.25),
        .B2     (0.125),
        .A1     (-0.5),
        .A2     (0.25),
        .INV_B0 (2.0)
    ) u_rt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (iv_rt),
        .in_ready  (ir_rt),
        .in_data   (in_data),
        .out_valid (ov_rt),
        .out_ready (or_rt),
        .out_data  (od_rt)
    );

    task automatic check(input string tag, input longint obs, input longint exp,
                         input longint tol = 0);
        longint d;
        checks++;
        d = obs - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
    endtask

    // One full transaction with out_ready held high; ends at the negedge after the output handshake.
    task automatic xfer(input logic [W-1:0] din, output logic signed [W-1:0] dout);
        int n;
        dout      = '0;
        in_data   = din;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            cyc();
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        cyc();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            cyc();
            n++;
        end
        check("out_valid_timeout", out_valid, 1);
        dout = out_data;
        cyc();
    endtask

    // Biquad impulse response x = 0.5, 0.5, 0.25, 0, -0.0625 must invert to a unit impulse.
    task automatic imp_check(input string tag);
        longint xv[5] = '{32768, 32768, 16384, 0, -4096};
        logic signed [W-1:0] got;
        for (int i = 0; i < 5; i++) begin
            xfer(W'(xv[i]), got);
            check(tag, got, (i == 0) ? 65536 : 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic signed [W-1:0] got;
        logic signed [W-1:0] gq[$];
        int     lat;
        int     n;
        real    xf, xh1, xh2, uh1, uh2;
        longint ui, xq;

        // Reset
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready_id", in_ready, 1);
        check("rst_out_data_id", out_data, 0);
        sel = 1'b1;
        #1;
        check("rst_in_ready_rt", in_ready, 1);
        check("rst_out_valid_rt", out_valid, 0);
        check("rst_out_data_rt", out_data, 0);
        sel = 1'b0;
        @(negedge clk);

        // Identity and latency: lat counts edges after the accepting edge
        in_data   = 32'h0001_0000;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check("id_in_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            cyc();
            lat++;
        end
        check("id_latency", lat, 5);
        check("id_out_data", out_data, 32'h0001_0000);
        check("id_hold_in_ready", in_ready, 0);
        cyc();
        check("id_post_out_valid", out_valid, 0);
        check("id_post_in_ready", in_ready, 1);

        // Backpressure
        in_data   = 32'h0003_0000;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        cyc();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            cyc();
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, 32'h0003_0000);
            check("bp_in_ready", in_ready, 0);
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);
        check("bp_data_held", out_data, 32'h0003_0000);

        // Input gating: fresh data every cycle, accepts expected at edges 0,7,...,35
        in_valid = 1'b1;
        for (int k = 0; k < 42; k++) begin
            if (out_valid) gq.push_back(out_data);
            in_data = 32'h0010_0000 + W'(k) * 32'h0001_0000;
            cyc();
        end
        in_valid = 1'b0;
        check("gate_count", gq.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check("gate_data", (i < gq.size()) ? longint'(gq[i]) : longint'(0),
                  32'h0010_0000 + i * 7 * 32'h0001_0000);
        end
        cyc();

        // Round trip through a float biquad: impulse then ramp of 1.5 per sample
        sel = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            clear();
            xh1 = 0.0; xh2 = 0.0; uh1 = 0.0; uh2 = 0.0;
            for (int k = 0; k < 64; k++) begin
                if (pass == 0) ui = (k == 0) ? 65536 : 0;
                else           ui = longint'(k) * 98304;
                xf = 0.5 * real'(ui) + 0.25 * uh1 + 0.125 * uh2 + 0.5 * xh1 - 0.25 * xh2;
                xq = longint'(xf);
                xfer(W'(xq), got);
                check((pass == 0) ? "rt_impulse" : "rt_ramp", got, ui, 2);
                xh2 = xh1; xh1 = xf;
                uh2 = uh1; uh1 = real'(ui);
            end
        end

        // Saturation at both rails
        clear();
        xfer(32'h7FFF_0000, got);
        check("sat_pos", got, 64'sd2147483647);
        clear();
        xfer(32'h8000_0000, got);
        check("sat_neg", got, -64'sd2147483648);

        // clr during MAC step 2 discards the sample and history
        clear();
        xfer(32'h0005_0000, got);
        xfer(32'h0003_0000, got);
        in_data   = 32'h0002_0000;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("clr_no_valid", out_valid, 0);
            cyc();
        end
        check("clr_in_ready", in_ready, 1);
        imp_check("clr_impulse");

        // Asynchronous reset while holding an output
        xfer(32'h0005_0000, got);
        in_data   = 32'h0002_0000;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        cyc();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            cyc();
            n++;
        end
        check("hold_before_rst", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_valid", out_valid, 0);
        check("rst_async_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_ready", in_ready, 1);
        imp_check("rst_impulse");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
